// File: rtl/micro_seq_pkg.sv
// micro_seq_pkg: shared source/stack-op encodings and width helper for the microprogram sequencer
package micro_seq_pkg;
  typedef enum logic [1:0] {SRC_UPC = 2'd0, SRC_AR = 2'd1, SRC_STACK = 2'd2, SRC_D = 2'd3} src_e;
  typedef enum logic [1:0] {OP_NONE = 2'd0, OP_PUSH = 2'd1, OP_POP = 2'd2} stack_op_e;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/micro_seq_if.sv
// micro_seq_if: control/address bundle between the microcode pipeline and the sequencer
interface micro_seq_if import micro_seq_pkg::*; #(
  parameter int ADDR_W   = 11,
  parameter int NUM_COND = 8
) ();
  localparam int COND_SEL_W = clog2(NUM_COND);
  logic [ADDR_W-1:0]     d_in, r_in, or_in, y_out;
  logic [1:0]            src_sel;
  logic                  re_n, fe_n, pup, zero_n, cin;
  logic [NUM_COND-1:0]   cond_in;
  logic [COND_SEL_W-1:0] cond_sel;
  logic                  cond_pol, cond_en, stall, clr_err;
  logic                  cout, stack_full, stack_empty, stack_err;
  modport master (
    output d_in, r_in, or_in, src_sel, re_n, fe_n, pup, zero_n, cin,
           cond_in, cond_sel, cond_pol, cond_en, stall, clr_err,
    input  y_out, cout, stack_full, stack_empty, stack_err
  );
  modport slave (
    input  d_in, r_in, or_in, src_sel, re_n, fe_n, pup, zero_n, cin,
           cond_in, cond_sel, cond_pol, cond_en, stall, clr_err,
    output y_out, cout, stack_full, stack_empty, stack_err
  );
endinterface

// File: rtl/micro_seq_stack.sv
// micro_seq_stack: STACK_DEPTH x ADDR_W LIFO; overflow/underflow leave state untouched and pulse err
module micro_seq_stack import micro_seq_pkg::*; #(
  parameter int ADDR_W      = 11,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] top,
  output logic              full,
  output logic              empty,
  output logic              err_pulse
);
  localparam int SP_W  = clog2(STACK_DEPTH + 1);
  localparam int IDX_W = clog2(STACK_DEPTH);
  logic [SP_W-1:0]   sp_q, sp_d;
  logic [ADDR_W-1:0] mem_q [STACK_DEPTH];
  logic [ADDR_W-1:0] mem_d [STACK_DEPTH];
  always_comb begin
    full = sp_q == SP_W'(STACK_DEPTH);
    empty = sp_q == '0;
    err_pulse = (push && full) || (pop && empty);
    top = empty ? '0 : mem_q[IDX_W'(sp_q - 1'b1)];
    mem_d = mem_q;
    sp_d = sp_q;
    if (push && !full) begin
      mem_d[IDX_W'(sp_q)] = din;
      sp_d = sp_q + 1'b1;
    end else if (pop && !empty) begin
      sp_d = sp_q - 1'b1;
    end
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sp_q <= '0;
      mem_q <= '{default: '0};
    end else begin
      sp_q <= sp_d;
      mem_q <= mem_d;
    end
  end
endmodule

// File: rtl/micro_sequencer.sv
// micro_sequencer: next-microaddress generator (uPC/AR/stack/direct) with conditional branch,
// stall hold and a sticky stack-error flag
module micro_sequencer import micro_seq_pkg::*; #(
  parameter int ADDR_W      = 11,
  parameter int STACK_DEPTH = 4,
  parameter int NUM_COND    = 8
) (
  input logic      clock,
  input logic      reset,
  micro_seq_if.slave bus
);
  logic [ADDR_W-1:0] upc_q, upc_d, ar_q, ar_d, top, mux, y, inc;
  logic              stack_err_q, stack_err_d, taken, push, pop, err_pulse, full, empty, cout;
  src_e              eff_src;
  stack_op_e         op;
  // A failed condition falls through to uPC and cancels the stack op, but never the AR load.
  always_comb begin
    taken = !bus.cond_en || (bus.cond_in[bus.cond_sel] ^ bus.cond_pol);
    eff_src = taken ? src_e'(bus.src_sel) : SRC_UPC;
    op = (bus.fe_n || !taken) ? OP_NONE : bus.pup ? OP_PUSH : OP_POP;
    push = !bus.stall && op == OP_PUSH;
    pop = !bus.stall && op == OP_POP;
    mux = eff_src == SRC_UPC ? upc_q : eff_src == SRC_AR ? ar_q : eff_src == SRC_STACK ? top : bus.d_in;
    y = bus.zero_n ? (mux | bus.or_in) : '0;
    {cout, inc} = {1'b0, y} + (ADDR_W + 1)'(bus.cin);
    upc_d = bus.stall ? upc_q : inc;
    ar_d = (!bus.stall && !bus.re_n) ? bus.r_in : ar_q;
    stack_err_d = bus.stall ? stack_err_q : (err_pulse || (!bus.clr_err && stack_err_q));
  end
  assign bus.y_out = y;
  assign bus.cout = cout;
  assign bus.stack_full = full;
  assign bus.stack_empty = empty;
  assign bus.stack_err = stack_err_q;
  micro_seq_stack #(.ADDR_W(ADDR_W), .STACK_DEPTH(STACK_DEPTH)) u_stack (
    .clock(clock), .reset(reset), .push(push), .pop(pop), .din(upc_q),
    .top(top), .full(full), .empty(empty), .err_pulse(err_pulse)
  );
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      upc_q <= '0;
      ar_q <= '0;
      stack_err_q <= 1'b0;
    end else begin
      upc_q <= upc_d;
      ar_q <= ar_d;
      stack_err_q <= stack_err_d;
    end
  end
endmodule
